sobel_gradient_core: RTL

SOBEL_GRADIENT_CORE -- requirements
Module: sobel_gradient_core

---
 rtl/sobel_gradient_core_if.sv | 28 ++
 rtl/sobel_gradient_core.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sobel_gradient_core_if.sv
// Request/result bundle for the Sobel gradient core. The requester drives
// the window and the handshake; the core drives the result.
interface sobel_gradient_core_if #(
    parameter int PIX_W = 8
);
    logic             i_start;
    logic [PIX_W-1:0] i_p0, i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8;
    logic [1:0]       i_mode;
    logic             i_thresh_wr;
    logic [PIX_W-1:0] i_thresh;
    logic             i_ack;
    logic             o_busy;
    logic             o_valid;
    logic [PIX_W-1:0] o_sum;
    logic             o_dir;

    modport master (
        output i_start, i_p0, i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8,
        output i_mode, i_thresh_wr, i_thresh, i_ack,
        input  o_busy, o_valid, o_sum, o_dir
    );

    modport slave (
        input  i_start, i_p0, i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7, i_p8,
        input  i_mode, i_thresh_wr, i_thresh, i_ack,
        output o_busy, o_valid, o_sum, o_dir
    );
endinterface

// File: rtl/sobel_gradient_core.sv
// Multi-cycle Sobel gradient magnitude on one captured 3x3 window, with
// L1 / max / threshold combine modes and a valid/ack result handshake.
module sobel_gradient_core #(
    parameter int PIX_W      = 8,
    parameter int DEF_THRESH = 2 ** (PIX_W - 1)
) (
    input logic                 clk,
    input logic                 n_rst,
    sobel_gradient_core_if.slave bus
);
    localparam int GW = PIX_W + 3;
    localparam int AW = PIX_W + 2;
    localparam logic [PIX_W-1:0] THRESH_RST = DEF_THRESH[PIX_W-1:0];

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC_X = 3'd1;
    localparam logic [2:0] S_CALC_Y = 3'd2;
    localparam logic [2:0] S_ABS    = 3'd3;
    localparam logic [2:0] S_COMB   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]              state_r, next_state_s;
    logic                    busy_r, valid_r, dir_r;
    logic [PIX_W-1:0]        sum_r, thresh_r, job_thresh_r;
    logic [PIX_W-1:0]        p_r [0:8];
    logic [1:0]              mode_r;
    logic signed [GW-1:0]    gx_r, gy_r;
    logic [AW-1:0]           ax_r, ay_r;

    logic [GW-1:0]           gx_s, gy_s, gx_mag_s, gy_mag_s, l1_s, m_s;
    logic [AW-1:0]           max_s;
    logic [PIX_W-1:0]        sum_s;

    // Next-state decode; start is only honoured in IDLE, ack only in DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:   if (bus.i_start) next_state_s = S_CALC_X; else next_state_s = S_IDLE;
            S_CALC_X: next_state_s = S_CALC_Y;
            S_CALC_Y: next_state_s = S_ABS;
            S_ABS:    next_state_s = S_COMB;
            S_COMB:   next_state_s = S_DONE;
            S_DONE:   if (bus.i_ack) next_state_s = S_IDLE; else next_state_s = S_DONE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Gradient arithmetic on the captured window, one stage per state.
    always_comb begin
        gx_s = (GW'(p_r[2]) + (GW'(p_r[5]) << 1) + GW'(p_r[8]))
             - (GW'(p_r[0]) + (GW'(p_r[3]) << 1) + GW'(p_r[6]));
        gy_s = (GW'(p_r[0]) + (GW'(p_r[1]) << 1) + GW'(p_r[2]))
             - (GW'(p_r[6]) + (GW'(p_r[7]) << 1) + GW'(p_r[8]));
        if (gx_r[GW-1]) gx_mag_s = -gx_r; else gx_mag_s = gx_r;
        if (gy_r[GW-1]) gy_mag_s = -gy_r; else gy_mag_s = gy_r;
        l1_s = GW'(ax_r) + GW'(ay_r);
        if (ay_r > ax_r) max_s = ay_r; else max_s = ax_r;
        case (mode_r)
            2'b01:   m_s = GW'(max_s);
            default: m_s = l1_s;
        endcase
        if (mode_r == 2'b10) begin
            if (l1_s >= GW'(job_thresh_r)) sum_s = {PIX_W{1'b1}};
            else                           sum_s = {PIX_W{1'b0}};
        end else if (|m_s[GW-1:PIX_W]) begin
            sum_s = {PIX_W{1'b1}};
        end else begin
            sum_s = m_s[PIX_W-1:0];
        end
    end

    // State, busy flag and the threshold register (writable in any state).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r  <= S_IDLE;
            busy_r   <= 1'b0;
            thresh_r <= THRESH_RST;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != S_IDLE);
            if (bus.i_thresh_wr) thresh_r <= bus.i_thresh;
        end
    end

    // Datapath registers and the held result.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 9; i++) p_r[i] <= {PIX_W{1'b0}};
            mode_r       <= 2'b00;
            job_thresh_r <= THRESH_RST;
            gx_r         <= {GW{1'b0}};
            gy_r         <= {GW{1'b0}};
            ax_r         <= {AW{1'b0}};
            ay_r         <= {AW{1'b0}};
            sum_r        <= {PIX_W{1'b0}};
            dir_r        <= 1'b0;
            valid_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.i_start) begin
                        p_r[0] <= bus.i_p0; p_r[1] <= bus.i_p1; p_r[2] <= bus.i_p2;
                        p_r[3] <= bus.i_p3; p_r[4] <= bus.i_p4; p_r[5] <= bus.i_p5;
                        p_r[6] <= bus.i_p6; p_r[7] <= bus.i_p7; p_r[8] <= bus.i_p8;
                        mode_r       <= bus.i_mode;
                        job_thresh_r <= thresh_r;
                    end
                end
                S_CALC_X: gx_r <= gx_s;
                S_CALC_Y: gy_r <= gy_s;
                S_ABS: begin
                    ax_r <= gx_mag_s[AW-1:0];
                    ay_r <= gy_mag_s[AW-1:0];
                end
                S_COMB: begin
                    sum_r   <= sum_s;
                    dir_r   <= (ay_r > ax_r);
                    valid_r <= 1'b1;
                end
                S_DONE: if (bus.i_ack) valid_r <= 1'b0;
                default: valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.o_busy  = busy_r;
    assign bus.o_valid = valid_r;
    assign bus.o_sum   = sum_r;
    assign bus.o_dir   = dir_r;
endmodule
